// File: rtl/key_conditioner_if.sv
// Key conditioner signal bundle: raw keys and repeat enables in, debounced level and event pulses out.
// The master side drives the keys; the slave side is the conditioner itself.
interface key_conditioner_if #(
  parameter int N_KEYS = 4
);
  logic [N_KEYS-1:0] key_raw;
  logic [N_KEYS-1:0] repeat_en;
  logic [N_KEYS-1:0] key_clean;
  logic [N_KEYS-1:0] press_pulse;
  logic [N_KEYS-1:0] release_pulse;
  logic [N_KEYS-1:0] repeat_pulse;

  modport master (
    output key_raw,
    output repeat_en,
    input  key_clean,
    input  press_pulse,
    input  release_pulse,
    input  repeat_pulse
  );

  modport slave (
    input  key_raw,
    input  repeat_en,
    output key_clean,
    output press_pulse,
    output release_pulse,
    output repeat_pulse
  );
endinterface

// File: rtl/key_conditioner.sv
// Push-button conditioner: per-key 2-flop synchronizer, persistence debounce,
// press/release edge pulses and an auto-repeat FSM, all in the clk_btn domain.
module key_conditioner #(
  parameter int N_KEYS          = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_RATE     = 10000000
) (
  input  logic             clk_btn,
  input  logic             rst_n_btn,
  key_conditioner_if.slave kif
);

  localparam int RP_N = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
  localparam int RP_W = $clog2(RP_N);

  localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0] DB_ONE     = DB_W'(1);
  localparam logic [RP_W-1:0] DELAY_LAST = RP_W'(REPEAT_DELAY - 1);
  localparam logic [RP_W-1:0] RATE_LAST  = RP_W'(REPEAT_RATE - 1);
  localparam logic [RP_W-1:0] RP_ONE     = RP_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } rep_state_t;

  logic [N_KEYS-1:0]           sync1_r;
  logic [N_KEYS-1:0]           sync2_r;
  logic [N_KEYS-1:0]           clean_r;
  logic [N_KEYS-1:0]           press_r;
  logic [N_KEYS-1:0]           release_r;
  logic [N_KEYS-1:0]           repeat_r;
  logic [N_KEYS-1:0][DB_W-1:0] db_cnt_r;
  logic [N_KEYS-1:0][RP_W-1:0] rp_cnt_r;
  rep_state_t                  state_r [N_KEYS];

  logic [N_KEYS-1:0] accept_s;
  logic [N_KEYS-1:0] fall_s;
  logic [N_KEYS-1:0] rise_s;
  logic [N_KEYS-1:0] stop_s;

  // Acceptance of a persisted level and the resulting edge/stop conditions.
  always_comb begin
    accept_s = '0;
    for (int i = 0; i < N_KEYS; i++) begin
      if ((sync2_r[i] != clean_r[i]) && (db_cnt_r[i] == DB_LAST)) begin
        accept_s[i] = 1'b1;
      end else begin
        accept_s[i] = 1'b0;
      end
    end
    fall_s = accept_s & ~sync2_r;
    rise_s = accept_s & sync2_r;
    // A release being accepted this edge must beat any repeat expiry.
    stop_s = rise_s | clean_r | ~kif.repeat_en;
  end

  // Two-flop synchronizer on the raw keys, idling high.
  always_ff @(posedge clk_btn or negedge rst_n_btn) begin
    if (!rst_n_btn) begin
      sync1_r <= '1;
      sync2_r <= '1;
    end else begin
      sync1_r <= kif.key_raw;
      sync2_r <= sync1_r;
    end
  end

  // Debounce counters, accepted level and the press/release pulses.
  always_ff @(posedge clk_btn or negedge rst_n_btn) begin
    if (!rst_n_btn) begin
      clean_r   <= '1;
      db_cnt_r  <= '0;
      press_r   <= '0;
      release_r <= '0;
    end else begin
      press_r   <= fall_s;
      release_r <= rise_s;
      for (int i = 0; i < N_KEYS; i++) begin
        if (sync2_r[i] == clean_r[i]) begin
          db_cnt_r[i] <= '0;
        end else if (db_cnt_r[i] == DB_LAST) begin
          clean_r[i]  <= sync2_r[i];
          db_cnt_r[i] <= '0;
        end else begin
          db_cnt_r[i] <= db_cnt_r[i] + DB_ONE;
        end
      end
    end
  end

  // Auto-repeat FSM: only a fresh press with repeat enabled can start it.
  always_ff @(posedge clk_btn or negedge rst_n_btn) begin
    if (!rst_n_btn) begin
      repeat_r <= '0;
      rp_cnt_r <= '0;
      for (int i = 0; i < N_KEYS; i++) begin
        state_r[i] <= ST_IDLE;
      end
    end else begin
      for (int i = 0; i < N_KEYS; i++) begin
        case (state_r[i])
          ST_IDLE: begin
            repeat_r[i] <= 1'b0;
            rp_cnt_r[i] <= '0;
            if (fall_s[i] && kif.repeat_en[i]) begin
              state_r[i] <= ST_DELAY;
            end else begin
              state_r[i] <= ST_IDLE;
            end
          end
          ST_DELAY: begin
            if (stop_s[i]) begin
              repeat_r[i] <= 1'b0;
              rp_cnt_r[i] <= '0;
              state_r[i]  <= ST_IDLE;
            end else if (rp_cnt_r[i] == DELAY_LAST) begin
              repeat_r[i] <= 1'b1;
              rp_cnt_r[i] <= '0;
              state_r[i]  <= ST_REPEAT;
            end else begin
              repeat_r[i] <= 1'b0;
              rp_cnt_r[i] <= rp_cnt_r[i] + RP_ONE;
              state_r[i]  <= ST_DELAY;
            end
          end
          ST_REPEAT: begin
            if (stop_s[i]) begin
              repeat_r[i] <= 1'b0;
              rp_cnt_r[i] <= '0;
              state_r[i]  <= ST_IDLE;
            end else if (rp_cnt_r[i] == RATE_LAST) begin
              repeat_r[i] <= 1'b1;
              rp_cnt_r[i] <= '0;
              state_r[i]  <= ST_REPEAT;
            end else begin
              repeat_r[i] <= 1'b0;
              rp_cnt_r[i] <= rp_cnt_r[i] + RP_ONE;
              state_r[i]  <= ST_REPEAT;
            end
          end
          default: begin
            repeat_r[i] <= 1'b0;
            rp_cnt_r[i] <= '0;
            state_r[i]  <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign kif.key_clean     = clean_r;
  assign kif.press_pulse   = press_r;
  assign kif.release_pulse = release_r;
  assign kif.repeat_pulse  = repeat_r;

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner with DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3.
module tb_key_conditioner;
  localparam int NK = 4;

  logic clk_btn = 1'b0;
  logic rst_n_btn;
  int   checks = 0;
  int   failures = 0;

  key_conditioner_if #(.N_KEYS(NK)) kif ();

  key_conditioner #(
    .N_KEYS(NK), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_RATE(3)
  ) dut (
    .clk_btn(clk_btn),
    .rst_n_btn(rst_n_btn),
    .kif(kif)
  );

  always #5 clk_btn = ~clk_btn;

  typedef struct {
    logic [3:0] raw;
    logic [3:0] en;
    logic [3:0] clean;
    logic [3:0] press;
    logic [3:0] rel;
    logic [3:0] rep;
  } vec_t;

  vec_t vecs[$];

  task automatic add_rows(input int n, input logic [3:0] raw, input logic [3:0] en,
                          input logic [3:0] clean, input logic [3:0] press,
                          input logic [3:0] rel, input logic [3:0] rep);
    for (int i = 0; i < n; i++) vecs.push_back('{raw, en, clean, press, rel, rep});
  endtask

  task automatic chk(input string name, input int idx, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d]: got %b, want %b", name, idx, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_btn);
    #1;
  endtask

  task automatic chk_all(input string tag, input int idx, input logic [3:0] c, input logic [3:0] p,
                         input logic [3:0] r, input logic [3:0] q);
    chk({tag, "_clean"}, idx, kif.key_clean, c);
    chk({tag, "_press"}, idx, kif.press_pulse, p);
    chk({tag, "_release"}, idx, kif.release_pulse, r);
    chk({tag, "_repeat"}, idx, kif.repeat_pulse, q);
  endtask

  // Hold key ch low for `hold` cycles with repeat enabled; expectations derived from the timing rules.
  task automatic run_hold(input int ch, input int hold, input string tag);
    logic [3:0] e_clean, e_press, e_rel, e_rep;
    kif.repeat_en = 4'b0000;
    kif.repeat_en[ch] = 1'b1;
    for (int c = 1; c <= hold + 12; c++) begin
      kif.key_raw = 4'b1111;
      if (c <= hold) kif.key_raw[ch] = 1'b0;
      tick();
      e_clean = 4'b1111; e_press = 4'b0000; e_rel = 4'b0000; e_rep = 4'b0000;
      if (c >= 6 && c <= hold + 5) e_clean[ch] = 1'b0;
      if (c == 6) e_press[ch] = 1'b1;
      if (c == hold + 6) e_rel[ch] = 1'b1;
      if (c >= 16 && c < hold + 6 && ((c - 16) % 3) == 0) e_rep[ch] = 1'b1;
      chk_all(tag, c, e_clean, e_press, e_rel, e_rep);
    end
    kif.repeat_en = 4'b0000;
  endtask

  initial begin
    // Scenario 1: get all keys accepted low, then reset asynchronously mid-cycle.
    rst_n_btn = 1'b0;
    kif.key_raw = 4'b0000;
    kif.repeat_en = 4'b0000;
    #12;
    rst_n_btn = 1'b1;
    repeat (8) tick();
    chk("pre_reset_clean", 0, kif.key_clean, 4'b0000);
    #2;
    rst_n_btn = 1'b0;
    #1;
    chk_all("async_reset", 0, 4'b1111, 4'b0000, 4'b0000, 4'b0000);
    kif.key_raw = 4'b1111;
    tick();
    chk_all("in_reset", 1, 4'b1111, 4'b0000, 4'b0000, 4'b0000);
    rst_n_btn = 1'b1;
    repeat (3) tick();

    // Scenario 2: clean press and release on key 0.
    add_rows(5, 4'b1110, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b0000);
    add_rows(1, 4'b1110, 4'b0000, 4'b1110, 4'b0001, 4'b0000, 4'b0000);
    add_rows(1, 4'b1110, 4'b0000, 4'b1110, 4'b0000, 4'b0000, 4'b0000);
    add_rows(5, 4'b1111, 4'b0000, 4'b1110, 4'b0000, 4'b0000, 4'b0000);
    add_rows(1, 4'b1111, 4'b0000, 4'b1111, 4'b0000, 4'b0001, 4'b0000);
    add_rows(1, 4'b1111, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b0000);
    // Scenario 3: bounce on key 1 is rejected, then a 6-cycle hold yields one press.
    add_rows(3, 4'b1101, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b0000);
    add_rows(1, 4'b1111, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b0000);
    add_rows(3, 4'b1101, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b0000);
    add_rows(4, 4'b1111, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b0000);
    add_rows(5, 4'b1101, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b0000);
    add_rows(1, 4'b1101, 4'b0000, 4'b1101, 4'b0010, 4'b0000, 4'b0000);
    add_rows(5, 4'b1111, 4'b0000, 4'b1101, 4'b0000, 4'b0000, 4'b0000);
    add_rows(1, 4'b1111, 4'b0000, 4'b1111, 4'b0000, 4'b0010, 4'b0000);
    add_rows(2, 4'b1111, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b0000);

    for (int i = 0; i < vecs.size(); i++) begin
      kif.key_raw = vecs[i].raw;
      kif.repeat_en = vecs[i].en;
      tick();
      chk_all("tbl", i, vecs[i].clean, vecs[i].press, vecs[i].rel, vecs[i].rep);
    end

    // Scenario 4: auto-repeat on key 2, release lands between repeat expiries.
    run_hold(2, 41, "repeat");
    // Scenario 5: release accepted on the same edge as a repeat expiry.
    run_hold(2, 40, "rel_vs_exp");

    // Scenario 6: reset while key 3 is held in the repeat phase.
    kif.repeat_en = 4'b1000;
    kif.key_raw = 4'b0111;
    repeat (20) tick();
    chk("hold3_clean", 0, kif.key_clean, 4'b0111);
    rst_n_btn = 1'b0;
    #1;
    chk_all("midhold_reset", 0, 4'b1111, 4'b0000, 4'b0000, 4'b0000);
    repeat (2) tick();
    chk_all("midhold_reset", 1, 4'b1111, 4'b0000, 4'b0000, 4'b0000);
    #3;
    rst_n_btn = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      chk_all("post_reset", c, (c >= 6) ? 4'b0111 : 4'b1111, (c == 6) ? 4'b1000 : 4'b0000,
              4'b0000, (c == 16 || c == 19) ? 4'b1000 : 4'b0000);
    end
    kif.key_raw = 4'b1111;
    kif.repeat_en = 4'b0000;
    repeat (8) tick();
    chk_all("final_idle", 0, 4'b1111, 4'b0000, 4'b0000, 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
